// File: rtl/router_header_rewrite_pkg.sv
// ============================================================================
// router_header_rewrite_pkg : header offsets, port codes and shared types
// Rev 1.0
// ============================================================================
`default_nettype none

package router_header_rewrite_pkg;

   localparam int HDR_DST_MAC_LSB   = 208;
   localparam int HDR_SRC_MAC_LSB   = 160;
   localparam int HDR_ETHERTYPE_LSB = 144;
   localparam int HDR_TTL_LSB       = 72;
   localparam int HDR_CSUM_LSB      = 48;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

   localparam logic [7:0] PORT0_CODE = 8'h01;
   localparam logic [7:0] PORT1_CODE = 8'h04;
   localparam logic [7:0] PORT2_CODE = 8'h10;
   localparam logic [7:0] PORT3_CODE = 8'h40;

   localparam logic [15:0] TTL_DEC_CONST = 16'h0100;

   typedef enum logic [0:0] {
      ST_HEADER = 1'b0,
      ST_BODY   = 1'b1
   } out_state_e;

   typedef struct packed {
      logic        arp_hit;
      logic [47:0] dest_mac;
      logic [7:0]  oq;
   } meta_t;

endpackage

`default_nettype wire

// File: rtl/fallthrough_small_fifo.sv
// ============================================================================
// fallthrough_small_fifo : small FIFO whose head entry is visible on dout_o
// Rev 1.0
// ============================================================================
`default_nettype none

module fallthrough_small_fifo #(
   parameter int WIDTH          = 8,
   parameter int MAX_DEPTH_BITS = 2,
   parameter int NEARLY_FULL    = (1 << MAX_DEPTH_BITS) - 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             wr_en_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             nearly_full_o,
   output logic             empty_o
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;

   logic [WIDTH-1:0]          mem_q [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
   logic [MAX_DEPTH_BITS:0]   count_q;
   logic                      w_wr;
   logic                      w_rd;

   assign full_o        = (count_q == (MAX_DEPTH_BITS+1)'(DEPTH));
   assign nearly_full_o = (count_q >= (MAX_DEPTH_BITS+1)'(NEARLY_FULL));
   assign empty_o       = (count_q == '0);
   assign dout_o        = mem_q[rd_ptr_q];

   assign w_wr = wr_en_i && !full_o;
   assign w_rd = rd_en_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (w_wr) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/ipv4_ttl_csum_update.sv
// ============================================================================
// ipv4_ttl_csum_update : TTL decrement with incremental one's-complement fix
// Rev 1.0
// ============================================================================
`default_nettype none

module ipv4_ttl_csum_update
   import router_header_rewrite_pkg::*;
(
   input  logic [7:0]  ttl_i,
   input  logic [15:0] csum_i,
   output logic [7:0]  ttl_o,
   output logic [15:0] csum_o
);

   logic [16:0] w_sum;

   assign ttl_o = ttl_i - 8'd1;
   assign w_sum = {1'b0, csum_i} + {1'b0, TTL_DEC_CONST};
   // After a carry the low half is at most 0x00FF, so the end-around add cannot carry again.
   assign csum_o = w_sum[15:0] + {15'd0, w_sum[16]};

endmodule

`default_nettype wire

// File: rtl/router_header_rewrite.sv
// ============================================================================
// router_header_rewrite : MAC/TTL/checksum/TUSER rewrite and CPU punt stage
// Rev 1.0
// ============================================================================
`default_nettype none

module router_header_rewrite
   import router_header_rewrite_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int SRC_PORT_POS         = 16,
   parameter int DST_PORT_POS         = 24
) (
   input  logic                              AXI_ACLK,
   input  logic                              AXI_RESETN,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
   input  logic                              S_AXIS_TVALID,
   input  logic                              S_AXIS_TLAST,
   output logic                              S_AXIS_TREADY,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
   output logic                              M_AXIS_TVALID,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY,
   input  logic                              arp_hit,
   input  logic [47:0]                       dest_mac,
   input  logic [31:0]                       oq_reg_out,
   input  logic [47:0]                       mac0,
   input  logic [47:0]                       mac1,
   input  logic [47:0]                       mac2,
   input  logic [47:0]                       mac3,
   output logic [31:0]                       fwd_count,
   output logic [31:0]                       punt_count
);

   localparam int DW     = C_S_AXIS_DATA_WIDTH;
   localparam int SW     = C_S_AXIS_DATA_WIDTH / 8;
   localparam int UW     = C_S_AXIS_TUSER_WIDTH;
   localparam int FIFO_W = 1 + UW + SW + DW;
   localparam int META_W = $bits(meta_t);

   logic              w_accept;
   logic              in_hdr_q;
   logic              meta_pend_q;
   logic              w_data_empty;
   logic              w_data_nfull;
   logic              w_meta_empty;
   logic [FIFO_W-1:0] w_data_dout;
   logic [META_W-1:0] w_meta_dout;
   meta_t             w_meta_din;
   meta_t             w_meta;
   logic              unused_data_full;
   logic              unused_meta_full;
   logic              unused_meta_nfull;
   logic              unused_oq_hi;

   logic [DW-1:0]     w_head_tdata;
   logic [SW-1:0]     w_head_tstrb;
   logic [UW-1:0]     w_head_tuser;
   logic              w_head_tlast;

   out_state_e        state_q;
   logic              w_out_fire;
   logic              w_hdr_fire;
   logic              w_bypass;
   logic              w_oq_ok;
   logic [47:0]       w_src_mac;
   logic              w_forward;
   logic              w_punt;
   logic [7:0]        w_src_byte;
   logic [7:0]        w_new_ttl;
   logic [15:0]       w_new_csum;
   logic [DW-1:0]     w_tdata_d;
   logic [UW-1:0]     w_tuser_d;
   logic [31:0]       fwd_count_q;
   logic [31:0]       punt_count_q;

   assign unused_oq_hi  = ^oq_reg_out[31:8];
   assign S_AXIS_TREADY = AXI_RESETN && !w_data_nfull;
   assign w_accept      = S_AXIS_TVALID && S_AXIS_TREADY;

   // Sideband from the ARP stage settles one cycle after the header beat is accepted.
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         in_hdr_q    <= 1'b1;
         meta_pend_q <= 1'b0;
      end else begin
         meta_pend_q <= w_accept && in_hdr_q;
         if (w_accept) in_hdr_q <= S_AXIS_TLAST;
      end
   end

   assign w_meta_din.arp_hit  = arp_hit;
   assign w_meta_din.dest_mac = dest_mac;
   assign w_meta_din.oq       = oq_reg_out[7:0];

   fallthrough_small_fifo #(
      .WIDTH          (FIFO_W),
      .MAX_DEPTH_BITS (2)
   ) u_data_fifo (
      .clk_i         (AXI_ACLK),
      .rst_n_i       (AXI_RESETN),
      .din_i         ({S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA}),
      .wr_en_i       (w_accept),
      .rd_en_i       (w_out_fire),
      .dout_o        (w_data_dout),
      .full_o        (unused_data_full),
      .nearly_full_o (w_data_nfull),
      .empty_o       (w_data_empty)
   );

   fallthrough_small_fifo #(
      .WIDTH          (META_W),
      .MAX_DEPTH_BITS (2)
   ) u_meta_fifo (
      .clk_i         (AXI_ACLK),
      .rst_n_i       (AXI_RESETN),
      .din_i         (w_meta_din),
      .wr_en_i       (meta_pend_q),
      .rd_en_i       (w_hdr_fire),
      .dout_o        (w_meta_dout),
      .full_o        (unused_meta_full),
      .nearly_full_o (unused_meta_nfull),
      .empty_o       (w_meta_empty)
   );

   assign w_meta = meta_t'(w_meta_dout);
   assign {w_head_tlast, w_head_tuser, w_head_tstrb, w_head_tdata} = w_data_dout;

   assign M_AXIS_TVALID = (state_q == ST_HEADER) ? (!w_data_empty && !w_meta_empty)
                                                 : !w_data_empty;
   assign w_out_fire    = M_AXIS_TVALID && M_AXIS_TREADY;
   assign w_hdr_fire    = w_out_fire && (state_q == ST_HEADER);

   always_comb begin
      w_oq_ok   = 1'b1;
      w_src_mac = '0;
      case (w_meta.oq)
         PORT0_CODE: w_src_mac = mac0;
         PORT1_CODE: w_src_mac = mac1;
         PORT2_CODE: w_src_mac = mac2;
         PORT3_CODE: w_src_mac = mac3;
         default:    w_oq_ok   = 1'b0;
      endcase
   end

   assign w_src_byte = w_head_tuser[SRC_PORT_POS +: 8];
   assign w_bypass   = (w_head_tuser[DST_PORT_POS +: 8] != 8'd0);
   assign w_forward  = w_meta.arp_hit && !w_bypass && w_oq_ok
                    && (w_head_tdata[HDR_ETHERTYPE_LSB +: 16] == ETHERTYPE_IPV4)
                    && (w_head_tdata[HDR_TTL_LSB +: 8] > 8'd1);
   assign w_punt     = !w_bypass && !w_forward;

   ipv4_ttl_csum_update u_ttl_csum (
      .ttl_i  (w_head_tdata[HDR_TTL_LSB +: 8]),
      .csum_i (w_head_tdata[HDR_CSUM_LSB +: 16]),
      .ttl_o  (w_new_ttl),
      .csum_o (w_new_csum)
   );

   always_comb begin
      w_tdata_d = w_head_tdata;
      w_tuser_d = w_head_tuser;
      if (state_q == ST_HEADER) begin
         if (w_forward) begin
            w_tdata_d[HDR_DST_MAC_LSB +: 48] = w_meta.dest_mac;
            w_tdata_d[HDR_SRC_MAC_LSB +: 48] = w_src_mac;
            w_tdata_d[HDR_TTL_LSB +: 8]      = w_new_ttl;
            w_tdata_d[HDR_CSUM_LSB +: 16]    = w_new_csum;
            w_tuser_d[DST_PORT_POS +: 8]     = w_meta.oq;
         end else if (w_punt) begin
            // CPU queue of port i sits one bit above the port's own one-hot bit.
            w_tuser_d[DST_PORT_POS +: 8]     = {w_src_byte[6:0], 1'b0};
         end
      end
   end

   assign M_AXIS_TDATA = w_tdata_d;
   assign M_AXIS_TUSER = w_tuser_d;
   assign M_AXIS_TSTRB = w_head_tstrb;
   assign M_AXIS_TLAST = w_head_tlast;

   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         state_q      <= ST_HEADER;
         fwd_count_q  <= '0;
         punt_count_q <= '0;
      end else if (w_out_fire) begin
         if (state_q == ST_HEADER) begin
            if (!w_head_tlast) state_q <= ST_BODY;
            if (w_forward)   fwd_count_q  <= fwd_count_q + 32'd1;
            else if (w_punt) punt_count_q <= punt_count_q + 32'd1;
         end else if (w_head_tlast) begin
            state_q <= ST_HEADER;
         end
      end
   end

   assign fwd_count  = fwd_count_q;
   assign punt_count = punt_count_q;

endmodule

`default_nettype wire

// File: tb/tb_router_header_rewrite.sv
// ============================================================================
// tb_router_header_rewrite : scoreboard bench for router_header_rewrite
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_router_header_rewrite;

   localparam logic [47:0] MAC0 = 48'h02_00_00_00_01_00;
   localparam logic [47:0] MAC1 = 48'h02_00_00_00_01_01;
   localparam logic [47:0] MAC2 = 48'h02_00_00_00_01_02;
   localparam logic [47:0] MAC3 = 48'h02_00_00_00_01_03;

   typedef struct {
      logic [255:0] d;
      logic [127:0] u;
      logic [31:0]  s;
      logic         l;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [255:0] s_tdata = '0;
   logic [31:0]  s_tstrb = '0;
   logic [127:0] s_tuser = '0;
   logic         s_tvalid = 1'b0;
   logic         s_tlast = 1'b0;
   logic         s_tready;
   logic [255:0] m_tdata;
   logic [31:0]  m_tstrb;
   logic [127:0] m_tuser;
   logic         m_tvalid;
   logic         m_tlast;
   logic         m_tready = 1'b1;
   logic         arp_hit = 1'b0;
   logic [47:0]  dest_mac = '0;
   logic [31:0]  oq_reg_out = '0;
   logic [31:0]  fwd_count;
   logic [31:0]  punt_count;

   logic         cur_hit = 1'b0;
   logic [47:0]  cur_dmac = '0;
   logic [31:0]  cur_oq = '0;
   logic         tb_in_hdr;

   beat_t        exp_q[$];
   int           n_checks = 0;
   int           n_pass = 0;
   int           exp_fwd = 0;
   int           exp_punt = 0;
   logic         saw_low;

   always #5 clk = ~clk;

   router_header_rewrite dut (
      .AXI_ACLK      (clk),
      .AXI_RESETN    (rst_n),
      .S_AXIS_TDATA  (s_tdata),
      .S_AXIS_TSTRB  (s_tstrb),
      .S_AXIS_TUSER  (s_tuser),
      .S_AXIS_TVALID (s_tvalid),
      .S_AXIS_TLAST  (s_tlast),
      .S_AXIS_TREADY (s_tready),
      .M_AXIS_TDATA  (m_tdata),
      .M_AXIS_TSTRB  (m_tstrb),
      .M_AXIS_TUSER  (m_tuser),
      .M_AXIS_TVALID (m_tvalid),
      .M_AXIS_TLAST  (m_tlast),
      .M_AXIS_TREADY (m_tready),
      .arp_hit       (arp_hit),
      .dest_mac      (dest_mac),
      .oq_reg_out    (oq_reg_out),
      .mac0          (MAC0),
      .mac1          (MAC1),
      .mac2          (MAC2),
      .mac3          (MAC3),
      .fwd_count     (fwd_count),
      .punt_count    (punt_count)
   );

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // ARP stage stand-in: results are registered one cycle after the header beat.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tb_in_hdr <= 1'b1;
      end else if (s_tvalid && s_tready) begin
         tb_in_hdr <= s_tlast;
         if (tb_in_hdr) begin
            arp_hit    <= cur_hit;
            dest_mac   <= cur_dmac;
            oq_reg_out <= cur_oq;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_beat", 256'(m_tvalid), 256'd0);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            check_val("m_tdata", m_tdata, e.d);
            check_val("m_tuser", 256'(m_tuser), 256'(e.u));
            check_val("m_tstrb", 256'(m_tstrb), 256'(e.s));
            check_val("m_tlast", 256'(m_tlast), 256'(e.l));
         end
      end
   end

   task automatic model_header(input beat_t i, input logic hit, input logic [47:0] dmac,
                               input logic [7:0] oq, output beat_t o);
      logic        byp;
      logic        ok;
      logic        fwd;
      logic [47:0] smac;
      logic [31:0] t;
      o    = i;
      byp  = (i.u[31:24] != 8'd0);
      ok   = 1'b1;
      smac = '0;
      case (oq)
         8'h01:   smac = MAC0;
         8'h04:   smac = MAC1;
         8'h10:   smac = MAC2;
         8'h40:   smac = MAC3;
         default: ok = 1'b0;
      endcase
      fwd = hit && !byp && ok && (i.d[159:144] == 16'h0800) && (i.d[79:72] > 8'd1);
      if (fwd) begin
         t = {16'd0, i.d[63:48]} + 32'h0000_0100;
         if (t > 32'h0000_FFFF) t = t - 32'h0000_FFFF;
         o.d[255:208] = dmac;
         o.d[207:160] = smac;
         o.d[79:72]   = i.d[79:72] - 8'd1;
         o.d[63:48]   = t[15:0];
         o.u[31:24]   = oq;
         exp_fwd++;
      end else if (!byp) begin
         o.u[31:24] = {i.u[22:16], 1'b0};
         exp_punt++;
      end
   endtask

   task automatic drive_beat(input beat_t x);
      int w = 0;
      s_tdata  = x.d;
      s_tuser  = x.u;
      s_tstrb  = x.s;
      s_tlast  = x.l;
      s_tvalid = 1'b1;
      while (!s_tready && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      if (!s_tready) check_val("s_tready_timeout", 256'(s_tready), 256'd1);
      @(posedge clk); #1;
      s_tvalid = 1'b0;
   endtask

   // Builds an nb-beat packet, scores it, then drives its first drv beats.
   task automatic send_pkt(input int nb, input int drv, input logic hit, input logic [47:0] dmac,
                           input logic [7:0] oq, input logic [7:0] dst, input logic [7:0] src,
                           input logic [15:0] eth, input logic [7:0] ttl, input logic [15:0] csum);
      beat_t b[$];
      beat_t e;
      for (int i = 0; i < nb; i++) begin
         beat_t x;
         x.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         x.u = {$urandom, $urandom, $urandom, $urandom};
         x.s = $urandom;
         x.l = (i == nb - 1);
         if (i == 0) begin
            x.d[159:144] = eth;
            x.d[79:72]   = ttl;
            x.d[63:48]   = csum;
            x.u[31:24]   = dst;
            x.u[23:16]   = src;
         end
         b.push_back(x);
      end
      model_header(b[0], hit, dmac, oq, e);
      exp_q.push_back(e);
      for (int i = 1; i < drv; i++) exp_q.push_back(b[i]);
      cur_hit  = hit;
      cur_dmac = dmac;
      cur_oq   = {24'($urandom), oq};
      for (int i = 0; i < drv; i++) drive_beat(b[i]);
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(posedge clk); #1;
         w++;
      end
      repeat (3) @(posedge clk);
      #1;
      check_val("drain", 256'(exp_q.size()), 256'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nbs [6]  = '{1, 3, 1, 3, 1, 3};
      int hits[6]  = '{1, 1, 1, 1, 1, 0};
      logic [7:0]  oqs [6] = '{8'h10, 8'h40, 8'h01, 8'h01, 8'h04, 8'h04};
      logic [15:0] eths[6] = '{16'h0800, 16'h0800, 16'h86DD, 16'h0800, 16'h0800, 16'h0800};
      logic [7:0]  ttls[6] = '{8'h40, 8'h80, 8'h40, 8'h05, 8'h02, 8'h40};
      beat_t       orphan;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_m_tvalid", 256'(m_tvalid), 256'd0);
      check_val("rst_s_tready", 256'(s_tready), 256'd0);
      check_val("rst_fwd", 256'(fwd_count), 256'd0);
      check_val("rst_punt", 256'(punt_count), 256'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("s_tready_idle", 256'(s_tready), 256'd1);

      // Latency and checksum wrap, with the output held off.
      m_tready = 1'b0;
      send_pkt(1, 1, 1'b1, 48'h02_00_00_00_00_BB, 8'h01, 8'h00, 8'h04, 16'h0800, 8'h20, 16'hFF80);
      check_val("lat_edge_k", 256'(m_tvalid), 256'd0);
      @(posedge clk); #1;
      check_val("lat_edge_k1", 256'(m_tvalid), 256'd1);
      check_val("csum_wrap", 256'(m_tdata[63:48]), 256'h0081);
      m_tready = 1'b1;
      drain();

      send_pkt(2, 2, 1'b1, 48'h02_00_00_00_00_AA, 8'h04, 8'h00, 8'h01, 16'h0800, 8'h40, 16'hB1E6);
      drain();
      check_val("fwd_after_hit", 256'(fwd_count), 256'(exp_fwd));

      send_pkt(2, 2, 1'b0, 48'h02_00_00_00_00_CC, 8'h04, 8'h00, 8'h10, 16'h0800, 8'h40, 16'h1234);
      send_pkt(1, 1, 1'b1, 48'h02_00_00_00_00_CC, 8'h04, 8'h00, 8'h10, 16'h0800, 8'h01, 16'h1234);
      send_pkt(3, 3, 1'b1, 48'h02_00_00_00_00_CC, 8'h03, 8'h00, 8'h10, 16'h0800, 8'h40, 16'h1234);
      drain();
      check_val("punt_count", 256'(punt_count), 256'(exp_punt));

      send_pkt(2, 2, 1'b1, 48'h02_00_00_00_00_DD, 8'h04, 8'h01, 8'h04, 16'h0800, 8'h40, 16'h5555);
      drain();
      check_val("bypass_fwd", 256'(fwd_count), 256'(exp_fwd));
      check_val("bypass_punt", 256'(punt_count), 256'(exp_punt));

      // Back-to-back mixed packets with a 10-cycle output stall.
      saw_low = 1'b0;
      fork
         begin
            for (int p = 0; p < 6; p++)
               send_pkt(nbs[p], nbs[p], hits[p][0], 48'h02_00_00_00_10_00 | 48'(p), oqs[p],
                        8'h00, 8'h40, eths[p], ttls[p], 16'(16'hA000 + p));
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            m_tready = 1'b0;
            repeat (10) begin
               @(posedge clk); #1;
               if (!s_tready) saw_low = 1'b1;
            end
            m_tready = 1'b1;
         end
      join
      drain();
      check_val("s_tready_dropped", 256'(saw_low), 256'd1);
      check_val("bp_fwd", 256'(fwd_count), 256'(exp_fwd));
      check_val("bp_punt", 256'(punt_count), 256'(exp_punt));

      // Reset while the FSM is in BODY with a body beat waiting.
      send_pkt(3, 1, 1'b1, 48'h02_00_00_00_00_EE, 8'h10, 8'h00, 8'h01, 16'h0800, 8'h40, 16'h2222);
      drain();
      m_tready = 1'b0;
      orphan.d = {8{$urandom}};
      orphan.u = {4{$urandom}};
      orphan.s = $urandom;
      orphan.l = 1'b0;
      drive_beat(orphan);
      repeat (2) @(posedge clk);
      #1;
      check_val("body_valid", 256'(m_tvalid), 256'd1);
      rst_n = 1'b0;
      #1;
      check_val("midrst_m_tvalid", 256'(m_tvalid), 256'd0);
      check_val("midrst_s_tready", 256'(s_tready), 256'd0);
      check_val("midrst_fwd", 256'(fwd_count), 256'd0);
      check_val("midrst_punt", 256'(punt_count), 256'd0);
      exp_q.delete();
      exp_fwd  = 0;
      exp_punt = 0;
      @(posedge clk); #1;
      rst_n    = 1'b1;
      m_tready = 1'b1;
      @(posedge clk); #1;
      send_pkt(1, 1, 1'b1, 48'h02_00_00_00_00_FF, 8'h40, 8'h00, 8'h01, 16'h0800, 8'h09, 16'h0F0F);
      drain();
      check_val("post_rst_fwd", 256'(fwd_count), 256'(exp_fwd));
      check_val("post_rst_punt", 256'(punt_count), 256'(exp_punt));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
